aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Round sequencer for the 128-bit AES datapath. It drives the load enables and input selects of the 128-bit state register and the round-key register. It also generates the round index, the round constant (Rcon) and the last-round flag that tell the combinational round logic what to compute. Every encryption starts with one `start` pulse, and the block answers with a one-cycle `done` pulse.

## Interface
- `NR`, default 10: number of AES rounds; legal range 2..15. The values 10, 12 and 14 are meaningful for AES.
- `RW`, default 4: round index width; must satisfy `2^RW > NR`.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a new encryption; sampled only in IDLE.
- `abort`, input, 1: cancel the operation in progress.
- `busy`, output, 1: high in INIT, ROUND, FINAL and DONE.
- `done`, output, 1: one-cycle pulse; the state register holds the ciphertext.
- `state_en`, output, 1: load enable for the 128-bit state register.
- `state_sel`, output, 1: state register input select. 0 = plaintext XOR cipher key; 1 = round-logic output.
- `key_en`, output, 1: load enable for the 128-bit round-key register.
- `key_sel`, output, 1: key register input select. 0 = cipher key; 1 = next round key from expansion.
- `round`, output, RW: current round index.
- `rcon`, output, 8: Rcon for the current round.
- `last_round`, output, 1: high only in FINAL; the round logic bypasses MixColumns.

## Operation
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- All outputs are Moore-decoded from the registered state, `round` and `rcon`.
- IDLE
  - Enables low, `busy = 0`.
  - `start = 1` and `abort = 0` → INIT.
  - `abort = 1` in IDLE keeps the FSM in IDLE and wins over `start`.
- INIT (1 cycle)
  - `state_en = 1`, `state_sel = 0`, `key_en = 1`, `key_sel = 0`.
  - `round = 0`, `rcon = 8'h01`.
  - Next state is ROUND, with `round` ← 1.
- ROUND
  - `state_en = 1`, `state_sel = 1`, `key_en = 1`, `key_sel = 1`, `last_round = 0`.
  - The key datapath computes round key r combinationally from the key register (which holds key r-1) and `rcon`. It loads that key on the same edge the state loads round r.
  - Each cycle: `round` ← `round` + 1, and `rcon` ← xtime(`rcon`).
  - When `round == NR-1`, next state is FINAL.
- FINAL (1 cycle)
  - Same enables as ROUND.
  - `round = NR`, `last_round = 1`.
  - Next state is DONE.
- DONE (1 cycle)
  - `done = 1`, enables low.
  - Next state is IDLE; `round` ← 0 and `rcon` ← 8'h01.
- xtime rule: if `rcon[7]` is set, the result is `{rcon[6:0],1'b0} ^ 8'h1b`; otherwise it is `{rcon[6:0],1'b0}`.
- Resulting Rcon sequence for rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- `start` outside IDLE is ignored, not queued.
- `abort` in INIT, ROUND or FINAL:
  - Next state is IDLE.
  - `round` ← 0, `rcon` ← 8'h01.
  - No `done` pulse; enables go low from the next cycle on.
  - The state register content is undefined afterwards.
- `abort` in DONE: `done` still pulses in that cycle, and the FSM returns to IDLE as usual.
- Special case `NR == 2`: the single ROUND cycle (round 1) goes straight to FINAL.

## Timing
- Reset values, applied immediately on `rst` without a clock edge:
  - FSM in IDLE.
  - `busy = 0`, `done = 0`, `state_en = 0`, `state_sel = 0`, `key_en = 0`, `key_sel = 0`.
  - `round = 0`, `rcon = 8'h01`, `last_round = 0`.
- Reset mid-operation discards the run and produces no `done`.
- Cycle numbering, with `start` sampled high in IDLE at cycle 0:
  - Cycle 1: INIT.
  - Cycles 2..NR: ROUND, rounds 1..NR-1.
  - Cycle NR+1: FINAL.
  - Cycle NR+2: DONE.
  - Cycle NR+3: IDLE.
- Start-to-done latency is NR+2 cycles. For NR = 10, `done` is high at cycle 12.
- Ciphertext is valid in the state register from cycle NR+2 until the next INIT load.
- Throughput: one operation per NR+3 cycles. If `start` is held high, the next INIT follows at cycle NR+4.
- `state_en` and `key_en` are high for exactly NR+1 consecutive cycles per completed run.

## Test plan
- **Basic run, NR = 10.**
  - Stimulus: release reset, pulse `start` at cycle 0.
  - Required: INIT at cycle 1; `round` = 1..9 over cycles 2..10 with `rcon` = 01, 02, 04, 08, 10, 20, 40, 80, 1b; FINAL at cycle 11 with `round = 10`, `rcon = 36`, `last_round = 1`; `done` high only at cycle 12; `busy` low at cycle 13.
- **Start held high.**
  - Stimulus: hold `start = 1` continuously.
  - Required: `done` pulses at cycles 12, 25, 38; each run shows `round` restarting at 0 and `rcon` at 01.
- **Start during busy.**
  - Stimulus: pulse `start` again at cycles 5 and 11.
  - Required: no change to the sequence; exactly one `done`, at cycle 12.
- **Abort mid-run.**
  - Stimulus: `abort = 1` in the cycle where `round = 5`.
  - Required: IDLE next cycle with enables 0, `round = 0`, `rcon = 01`; no `done`. A following `start` gives a full 12-cycle run.
- **Asynchronous reset mid-run.**
  - Stimulus: assert `rst` between clock edges while `round = 7`.
  - Required: `busy`, `state_en`, `key_en` = 0, `round = 0`, `rcon = 01` before the next edge; `start` after release behaves as in the basic run.
- **Abort and start together, plus NR = 14 variant.**
  - Stimulus: in IDLE, assert `abort` and `start` in the same cycle.
  - Required: stays in IDLE.
  - With NR = 14, a normal run gives `done` at cycle 16 and `rcon` sequence 01..36, 6c, d8, ab, 4d.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steps the 128-bit state and round-key registers through
// one initial key addition, NR-1 full rounds and one final round. It produces
// the round index, the round constant and the last-round flag for the
// combinational round logic.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          state_en,
  output logic          state_sel,
  output logic          key_en,
  output logic          key_sel,
  output logic [RW-1:0] round,
  output logic [7:0]    rcon,
  output logic          last_round
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Index of the last full round; from here the next round is the final one.
  localparam logic [RW-1:0] ROUND_LAST = RW'(NR - 1);
  localparam logic [RW-1:0] ROUND_ONE  = RW'(1);
  localparam logic [7:0]    RCON_INIT  = 8'h01;

  state_t        st, st_nxt;
  logic [RW-1:0] round_q, round_nxt;
  logic [7:0]    rcon_q, rcon_nxt;

  // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    logic [7:0] sh;
    sh = {v[6:0], 1'b0};
    return v[7] ? (sh ^ 8'h1b) : sh;
  endfunction

  // State, round counter and round constant registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      round_q <= '0;
      rcon_q  <= RCON_INIT;
    end else begin
      st      <= st_nxt;
      round_q <= round_nxt;
      rcon_q  <= rcon_nxt;
    end
  end

  // Next-state logic. An abort during the run goes back to IDLE and rewinds
  // round and rcon so that the next start begins cleanly.
  always_comb begin
    st_nxt    = st;
    round_nxt = round_q;
    rcon_nxt  = rcon_q;
    case (st)
      IDLE: begin
        // Abort wins over start so a stuck abort can hold the block idle.
        if (start && !abort) begin
          st_nxt = INIT;
        end
      end
      INIT: begin
        if (abort) begin
          st_nxt    = IDLE;
          round_nxt = '0;
          rcon_nxt  = RCON_INIT;
        end else begin
          // Round 1 uses the initial rcon; the key register now holds key 0.
          st_nxt    = ROUND;
          round_nxt = ROUND_ONE;
        end
      end
      ROUND: begin
        if (abort) begin
          st_nxt    = IDLE;
          round_nxt = '0;
          rcon_nxt  = RCON_INIT;
        end else begin
          round_nxt = round_q + ROUND_ONE;
          rcon_nxt  = xtime(rcon_q);
          if (round_q == ROUND_LAST) begin
            st_nxt = FINAL;
          end
        end
      end
      FINAL: begin
        if (abort) begin
          st_nxt    = IDLE;
          round_nxt = '0;
          rcon_nxt  = RCON_INIT;
        end else begin
          st_nxt = DONE;
        end
      end
      DONE: begin
        // The ciphertext is already in the state register, so abort has no
        // effect here and done still pulses.
        st_nxt    = IDLE;
        round_nxt = '0;
        rcon_nxt  = RCON_INIT;
      end
      default: begin
        st_nxt    = IDLE;
        round_nxt = '0;
        rcon_nxt  = RCON_INIT;
      end
    endcase
  end

  // Moore output decode of the register enables and input selects.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    state_en   = 1'b0;
    state_sel  = 1'b0;
    key_en     = 1'b0;
    key_sel    = 1'b0;
    last_round = 1'b0;
    case (st)
      INIT: begin
        // Load plaintext ^ key into the state register and the cipher key
        // into the key register.
        busy     = 1'b1;
        state_en = 1'b1;
        key_en   = 1'b1;
      end
      ROUND: begin
        busy      = 1'b1;
        state_en  = 1'b1;
        state_sel = 1'b1;
        key_en    = 1'b1;
        key_sel   = 1'b1;
      end
      FINAL: begin
        busy       = 1'b1;
        state_en   = 1'b1;
        state_sel  = 1'b1;
        key_en     = 1'b1;
        key_sel    = 1'b1;
        last_round = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign round = round_q;
  assign rcon  = rcon_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl. It runs NR=10 and NR=14 instances side by side on
// shared stimulus. A phase-count reference model pushes the expected outputs
// for each cycle into a queue, and a monitor pops those entries and compares
// them against each DUT.
module tb_aes_round_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       st_en;
    logic       st_sel;
    logic       k_en;
    logic       k_sel;
    logic       last;
    logic [3:0] round;
    logic [7:0] rcon;
    logic       chk_rk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic busy10, done10, se10, ss10, ke10, ks10, lr10;
  logic [3:0] rd10;
  logic [7:0] rc10;
  logic busy14, done14, se14, ss14, ke14, ks14, lr14;
  logic [3:0] rd14;
  logic [7:0] rc14;

  int checks = 0;
  int errors = 0;
  int k10 = 0;
  int k14 = 0;
  exp_t q10[$];
  exp_t q14[$];

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10), .RW(4)) dut10 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy10), .done(done10), .state_en(se10), .state_sel(ss10),
    .key_en(ke10), .key_sel(ks10), .round(rd10), .rcon(rc10), .last_round(lr10)
  );

  aes_round_ctrl #(.NR(14), .RW(4)) dut14 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy14), .done(done14), .state_en(se14), .state_sel(ss14),
    .key_en(ke14), .key_sel(ks14), .round(rd14), .rcon(rc14), .last_round(lr14)
  );

  // Rcon for round r is x^(r-1) reduced modulo the AES polynomial 0x11b.
  function automatic logic [7:0] rcon_ref(input int r);
    int v;
    v = 1 << (r - 1);
    for (int b = 14; b >= 8; b--) begin
      if (v[b]) v = v ^ (32'h11b << (b - 8));
    end
    return v[7:0];
  endfunction

  // Phase k is the number of cycles since start was accepted: 0 means idle,
  // 1 is init, 2..nr+1 carry rounds 1..nr, and nr+2 is done.
  function automatic exp_t expect_of(input int k, input int nr);
    exp_t e;
    e = '0;
    e.rcon = 8'h01;
    e.chk_rk = 1'b1;
    if (k == 1) begin
      e.busy = 1'b1; e.st_en = 1'b1; e.k_en = 1'b1;
    end else if (k >= 2 && k <= nr + 1) begin
      e.busy = 1'b1; e.st_en = 1'b1; e.st_sel = 1'b1; e.k_en = 1'b1; e.k_sel = 1'b1;
      e.last = (k == nr + 1);
      e.round = 4'(k - 1);
      e.rcon = rcon_ref(k - 1);
    end else if (k == nr + 2) begin
      e.busy = 1'b1; e.done = 1'b1; e.chk_rk = 1'b0;
    end
    return e;
  endfunction

  function automatic int step(input int k, input int nr, input logic s, input logic a);
    if (k == 0) return (s && !a) ? 1 : 0;
    if (k == nr + 2) return 0;
    if (a) return 0;
    return k + 1;
  endfunction

  // Reference model: advance on every edge and queue what the DUTs must show.
  always @(posedge clk) begin
    if (rst) begin
      k10 = 0;
      k14 = 0;
    end else begin
      k10 = step(k10, 10, start, abort);
      k14 = step(k14, 14, start, abort);
    end
    q10.push_back(expect_of(k10, 10));
    q14.push_back(expect_of(k14, 14));
  end

  task automatic check_dut(input string nm, input exp_t e, input logic [6:0] ctl,
                           input logic [3:0] rd, input logic [7:0] rc);
    logic [6:0] ectl;
    ectl = {e.busy, e.done, e.st_en, e.st_sel, e.k_en, e.k_sel, e.last};
    checks++;
    if (ctl !== ectl) begin
      errors++;
      $display("FAIL %s ctl(busy,done,sen,ssel,ken,ksel,last) got %b want %b at %0t",
               nm, ctl, ectl, $time);
    end
    if (e.chk_rk) begin
      checks++;
      if (rd !== e.round || rc !== e.rcon) begin
        errors++;
        $display("FAIL %s round/rcon got %0d/%h want %0d/%h at %0t",
                 nm, rd, rc, e.round, e.rcon, $time);
      end
    end
  endtask

  // Monitor: compare the oldest queued expectation on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q10.size() > 0) begin
      e = q10.pop_front();
      check_dut("nr10", e, {busy10, done10, se10, ss10, ke10, ks10, lr10}, rd10, rc10);
    end
    if (q14.size() > 0) begin
      e = q14.pop_front();
      check_dut("nr14", e, {busy14, done14, se14, ss14, ke14, ks14, lr14}, rd14, rc14);
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, got, want, $time);
    end
  endtask

  // Pulse start in cycle 0 and report the cycle each instance raises done.
  task automatic run_latency(input string nm);
    int d10;
    int d14;
    d10 = -1;
    d14 = -1;
    start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done10 && d10 < 0) d10 = n;
      if (done14 && d14 < 0) d14 = n;
    end
    chk({nm, "_lat10"}, d10, 12);
    chk({nm, "_lat14"}, d14, 16);
  endtask

  task automatic wait_round10(input int r, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      if (rd10 == 4'(r) && busy10) ok = 1'b1;
    end
  endtask

  initial begin
    int cnt;
    bit ok;
    int dq[$];

    // Reset state, applied without any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy10, 0);
    chk("rst_en", {se10, ke10, ss10, ks10, done10, lr10}, 0);
    chk("rst_round", rd10, 0);
    chk("rst_rcon", rc10, 8'h01);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic run.
    run_latency("basic");

    // Start pulses while busy are ignored.
    cnt = 0;
    start = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      start = (n == 5 || n == 11);
      if (done10) cnt++;
    end
    start = 1'b0;
    chk("busy_start_dones", cnt, 1);
    repeat (4) @(negedge clk);

    // Start held high gives back-to-back runs.
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done10) dq.push_back(n);
    end
    start = 1'b0;
    chk("held_count", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("held_d0", dq[0], 12);
      chk("held_d1", dq[1], 25);
      chk("held_d2", dq[2], 38);
    end
    repeat (20) @(negedge clk);

    // Abort in the round-5 cycle.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_round10(5, ok);
    chk("abort_reach_r5", ok, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy10, 0);
    chk("abort_en", {se10, ke10}, 0);
    chk("abort_round", rd10, 0);
    chk("abort_rcon", rc10, 8'h01);
    cnt = 0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (done10 || done14) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    run_latency("after_abort");
    repeat (4) @(negedge clk);

    // Asynchronous reset between edges while round is 7.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_round10(7, ok);
    chk("rst_reach_r7", ok, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy10, 0);
    chk("arst_en", {se10, ke10}, 0);
    chk("arst_round", rd10, 0);
    chk("arst_rcon", rc10, 8'h01);
    chk("arst_busy14", busy14, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_latency("after_rst");
    repeat (4) @(negedge clk);

    // Abort and start together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_idle10", busy10, 0);
    chk("abort_start_idle14", busy14, 0);
    repeat (2) @(negedge clk);

    // Random traffic, checked by the scoreboard.
    for (int n = 0; n < 900; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
